// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: reads one frame from memory as a series of fixed-size
// AXI4 INCR bursts and streams the beats out through a first-word
// fall-through FIFO. Each FIFO entry carries a start-of-frame tag.
// A new address is only issued when the FIFO can absorb a whole burst,
// so the read data channel never has to stall.
// Optional build macro: AXI_RRESP_CHECK_EN (non-OKAY RRESP sets rd_error).
module axi4_frame_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FRAME_BYTES    = 153600,
  parameter int BURST_BYTES    = 512,
  parameter int FIFO_DEPTH     = 128
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      buf_select,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_sof,
  output logic                      reader_done,
  output logic                      rd_error,
  output logic [1:0]                state,
  output logic [7:0]                fifo_level
);

  localparam int BEATS = BURST_BYTES / (AXI_DATA_WIDTH / 8);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]               LAST_OFFSET = 32'(FRAME_BYTES - BURST_BYTES);
  localparam logic [31:0]               BURST_INC   = 32'(BURST_BYTES);
  localparam logic [7:0]                LAST_BEAT   = 8'(BEATS - 1);
  localparam logic [CNT_W-1:0]          FILL_LIMIT  = CNT_W'(FIFO_DEPTH - BEATS);
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE0       = AXI_ADDR_WIDTH'(32'h0100_0000);
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE1       = AXI_ADDR_WIDTH'(32'h0110_0000);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_SEND = 2'd1,
    DATA_RECV = 2'd2,
    NEXT      = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]               offset_q, offset_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      sof_pending_q, sof_pending_d;
  logic                      rd_error_q, rd_error_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [AXI_DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic space_ok;
  logic last_burst;
  logic resp_err;

`ifdef AXI_RRESP_CHECK_EN
  assign resp_err = (RRESP != 2'b00);
`else
  logic unused_rresp;
  assign resp_err     = 1'b0;
  assign unused_rresp = ^RRESP;
`endif

  // Fixed burst shape: 64-bit beats, INCR, cacheable, non-secure data access.
  assign ARLEN   = LAST_BEAT;
  assign ARSIZE  = 3'b011;
  assign ARBURST = 2'b01;
  assign ARCACHE = 4'b1111;
  assign ARPROT  = 3'b010;

  assign space_ok    = (count_q <= FILL_LIMIT);
  assign last_burst  = (offset_q == LAST_OFFSET);
  assign ARADDR      = base_q + AXI_ADDR_WIDTH'(offset_q);
  assign ARVALID     = (state_q == ADDR_SEND) && space_ok;
  assign RREADY      = (state_q == DATA_RECV);
  assign push        = RVALID && RREADY;
  assign m_valid     = (count_q != '0);
  assign pop         = m_valid && m_ready;
  assign m_data      = mem_q[rd_ptr_q][AXI_DATA_WIDTH-1:0];
  assign m_sof       = m_valid && mem_q[rd_ptr_q][AXI_DATA_WIDTH];
  assign reader_done = (state_q == NEXT) && last_burst;
  assign rd_error    = rd_error_q;
  assign state       = state_q;
  assign fifo_level  = 8'(count_q);

  // Burst sequencing: address phase, 64-beat data phase, advance or finish.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    offset_d      = offset_q;
    beat_cnt_d    = beat_cnt_q;
    sof_pending_d = sof_pending_q;
    rd_error_d    = rd_error_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          base_d        = buf_select ? BASE1 : BASE0;
          offset_d      = '0;
          sof_pending_d = 1'b1;
          state_d       = ADDR_SEND;
        end
      end
      ADDR_SEND: begin
        if (ARVALID && ARREADY) state_d = DATA_RECV;
      end
      DATA_RECV: begin
        if (push) begin
          sof_pending_d = 1'b0;
          if (resp_err) rd_error_d = 1'b1;
          // The beat count, not RLAST, decides where the burst ends.
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = NEXT;
            if (!RLAST) rd_error_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (RLAST) rd_error_d = 1'b1;
          end
        end
      end
      NEXT: begin
        if (last_burst) begin
          state_d = IDLE;
        end else begin
          offset_d = offset_q + BURST_INC;
          state_d  = ADDR_SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      offset_q      <= '0;
      beat_cnt_q    <= '0;
      sof_pending_q <= 1'b0;
      rd_error_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      offset_q      <= offset_d;
      beat_cnt_q    <= beat_cnt_d;
      sof_pending_q <= sof_pending_d;
      rd_error_q    <= rd_error_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_100Mhz) begin
    if (push) mem_q[wr_ptr_q] <= {sof_pending_q, RDATA};
  end

endmodule

// File: tb/tb_axi4_frame_reader.sv
`timescale 1ns/1ps
module tb_axi4_frame_reader;

  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        buf_select = 1'b0;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [63:0] RDATA = '0;
  logic [1:0]  RRESP = 2'b00;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_sof;
  logic        reader_done;
  logic        rd_error;
  logic [1:0]  state;
  logic [7:0]  fifo_level;

`ifdef AXI_RRESP_CHECK_EN
  localparam logic RRESP_ERR_EXP = 1'b1;
`else
  localparam logic RRESP_ERR_EXP = 1'b0;
`endif

  axi4_frame_reader dut (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .frame_start(frame_start),
    .buf_select (buf_select),
    .ARADDR     (ARADDR),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .ARLEN      (ARLEN),
    .ARSIZE     (ARSIZE),
    .ARBURST    (ARBURST),
    .ARCACHE    (ARCACHE),
    .ARPROT     (ARPROT),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .RLAST      (RLAST),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .reader_done(reader_done),
    .rd_error   (rd_error),
    .state      (state),
    .fifo_level (fifo_level)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];
  logic [31:0] ar_log[$];
  int          phase = 0;
  int          beat = 0;
  int          ar_wait = 0;
  int          ar_wait_last = 0;
  int          ar_delay = 0;
  bit          ar_tracking = 0;
  logic [31:0] ar_held = '0;
  logic [31:0] cur_addr = '0;
  bit          tb_sof = 0;
  int          sink_budget = -1;
  int          words_popped = 0;
  int          sof_seen = 0;
  int          done_cnt = 0;
  int          beats_total = 0;
  int          bad_rlast_beat = -1;
  int          bad_rresp_beat = -1;
  bit          drop_last = 0;

  // Memory slave + stream sink + scoreboard; acts on falling edges so every
  // decision is in place before the next rising edge samples it.
  task automatic run_bfm();
    logic [64:0] exp;
    forever begin
      @(negedge clk_100Mhz);
      if (rst) begin
        ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 2'b00; m_ready = 0;
        phase = 0; beat = 0; ar_wait = 0; ar_tracking = 0; tb_sof = 0;
        exp_q.delete();
        continue;
      end
      if (reader_done) done_cnt++;
      m_ready = (sink_budget != 0);
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_unexpected: got %h, expected no word", {m_sof, m_data});
        end else begin
          exp = exp_q.pop_front();
          if ({m_sof, m_data} !== exp) begin
            errors++;
            $display("FAIL stream_word: got %h, expected %h", {m_sof, m_data}, exp);
          end
        end
        words_popped++;
        if (m_sof) sof_seen++;
        if (sink_budget > 0) sink_budget--;
      end
      ARREADY = 0;
      if (phase == 0) begin
        RVALID = 0; RLAST = 0; RRESP = 2'b00;
        if (ARVALID) begin
          if (ar_tracking) begin
            checks++;
            if (ARADDR !== ar_held) begin
              errors++;
              $display("FAIL araddr_stable: got %h, expected %h", ARADDR, ar_held);
            end
          end else begin
            ar_tracking = 1; ar_held = ARADDR; ar_wait = 0;
          end
          if (ar_wait >= ar_delay) begin
            ARREADY = 1; ar_log.push_back(ARADDR); ar_wait_last = ar_wait;
            cur_addr = ARADDR; phase = 1; beat = 0; ar_tracking = 0;
          end else begin
            ar_wait++;
          end
        end else if (ar_tracking) begin
          checks++; errors++;
          $display("FAIL arvalid_stable: got 0, expected 1 until handshake");
          ar_tracking = 0;
        end
      end else begin
        RVALID = 1;
        RDATA  = {cur_addr, 24'h0, 8'(beat)};
        RLAST  = ((beat == 63) && !drop_last) || (beat == bad_rlast_beat);
        RRESP  = (beat == bad_rresp_beat) ? 2'b10 : 2'b00;
        if (RREADY) begin
          exp_q.push_back({tb_sof, RDATA});
          tb_sof = 0; beat++; beats_total++;
          if (beat == 64) phase = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_100Mhz);
    #1 rst = 1; frame_start = 0;
    ar_log.delete(); words_popped = 0; sof_seen = 0; done_cnt = 0; beats_total = 0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_100Mhz);
    #1 rst = 0;
  endtask

  task automatic pulse_start(input logic sel);
    @(negedge clk_100Mhz);
    buf_select = sel; frame_start = 1; tb_sof = 1;
    @(negedge clk_100Mhz);
    frame_start = 0;
  endtask

  task automatic wait_ar(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100Mhz); #2;
      if (ar_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic clear_knobs();
    ar_delay = 0; sink_budget = -1; bad_rlast_beat = -1; bad_rresp_beat = -1; drop_last = 0;
  endtask

  task automatic test_reset();
    logic [31:0] got [15];
    logic [31:0] want [15];
    string       nm [15];
    do_reset();
    got[0]  = 32'(state);       want[0]  = 0;   nm[0]  = "state";
    got[1]  = 32'(ARVALID);     want[1]  = 0;   nm[1]  = "arvalid";
    got[2]  = 32'(RREADY);      want[2]  = 0;   nm[2]  = "rready";
    got[3]  = ARADDR;           want[3]  = 0;   nm[3]  = "araddr";
    got[4]  = 32'(m_valid);     want[4]  = 0;   nm[4]  = "m_valid";
    got[5]  = 32'(m_sof);       want[5]  = 0;   nm[5]  = "m_sof";
    got[6]  = 32'(fifo_level);  want[6]  = 0;   nm[6]  = "fifo_level";
    got[7]  = 32'(reader_done); want[7]  = 0;   nm[7]  = "reader_done";
    got[8]  = 32'(rd_error);    want[8]  = 0;   nm[8]  = "rd_error";
    got[9]  = 32'(ARLEN);       want[9]  = 63;  nm[9]  = "arlen";
    got[10] = 32'(ARSIZE);      want[10] = 3;   nm[10] = "arsize";
    got[11] = 32'(ARBURST);     want[11] = 1;   nm[11] = "arburst";
    got[12] = 32'(ARCACHE);     want[12] = 15;  nm[12] = "arcache";
    got[13] = 32'(ARPROT);      want[13] = 2;   nm[13] = "arprot";
    got[14] = 32'(m_ready);     want[14] = 0;   nm[14] = "tb_m_ready_idle";
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL reset_%s: got %h, expected %h", nm[i], got[i], want[i]);
      end
    end
    release_reset();
  endtask

  task automatic test_full_frame();
    bit injected = 0;
    int seq_bad = 0;
    logic [31:0] last_exp;
    clear_knobs();
    pulse_start(1'b0);
    for (int i = 0; i < 30000 && done_cnt == 0; i++) begin
      @(negedge clk_100Mhz); #2;
      if (!injected && ar_log.size() == 100) begin
        frame_start = 1; buf_select = 1; injected = 1;
        @(negedge clk_100Mhz); #2;
        frame_start = 0; buf_select = 0;
      end
    end
    repeat (100) @(negedge clk_100Mhz);
    #2;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL frame_done_pulses: got %0d, expected 1", done_cnt); end
    checks++;
    if (ar_log.size() !== 300) begin errors++; $display("FAIL frame_bursts: got %0d, expected 300", ar_log.size()); end
    if (ar_log.size() > 0) begin
      last_exp = 32'h0100_0000 + 32'(153600 - 512);
      checks++;
      if (ar_log[0] !== 32'h0100_0000) begin errors++; $display("FAIL frame_first_addr: got %h, expected 01000000", ar_log[0]); end
      checks++;
      if (ar_log[ar_log.size()-1] !== last_exp) begin
        errors++; $display("FAIL frame_last_addr: got %h, expected %h", ar_log[ar_log.size()-1], last_exp);
      end
      foreach (ar_log[k]) if (ar_log[k] !== 32'h0100_0000 + 32'(k * 512)) seq_bad++;
      checks++;
      if (seq_bad !== 0) begin errors++; $display("FAIL frame_addr_sequence: got %0d bad addresses, expected 0", seq_bad); end
    end
    checks++;
    if (words_popped !== 19200) begin errors++; $display("FAIL frame_words: got %0d, expected 19200", words_popped); end
    checks++;
    if (sof_seen !== 1) begin errors++; $display("FAIL frame_sof_count: got %0d, expected 1", sof_seen); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL frame_leftover: got %0d words, expected 0", exp_q.size()); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL frame_end_state: got %0d, expected 0", state); end
    checks++;
    if (rd_error !== 1'b0) begin errors++; $display("FAIL frame_rd_error: got %b, expected 0", rd_error); end
  endtask

  task automatic test_buf1();
    bit ok;
    do_reset(); release_reset(); clear_knobs();
    pulse_start(1'b1);
    wait_ar(2, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL buf1_timeout: got %0d bursts, expected 2", ar_log.size()); end
    else begin
      checks++;
      if (ar_log[0] !== 32'h0110_0000) begin errors++; $display("FAIL buf1_first_addr: got %h, expected 01100000", ar_log[0]); end
      checks++;
      if (ar_log[1] !== 32'h0110_0200) begin errors++; $display("FAIL buf1_second_addr: got %h, expected 01100200", ar_log[1]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(); release_reset(); clear_knobs();
    sink_budget = 0;
    pulse_start(1'b0);
    repeat (400) @(negedge clk_100Mhz);
    #2;
    checks++;
    if (ar_log.size() !== 2) begin errors++; $display("FAIL bp_bursts: got %0d, expected 2", ar_log.size()); end
    checks++;
    if (fifo_level !== 8'd128) begin errors++; $display("FAIL bp_level: got %0d, expected 128", fifo_level); end
    checks++;
    if (ARVALID !== 1'b0) begin errors++; $display("FAIL bp_arvalid: got %b, expected 0", ARVALID); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL bp_state: got %0d, expected 1", state); end
    sink_budget = 64;
    wait_ar(3, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_resume: got %0d bursts, expected 3", ar_log.size()); end
    else begin
      checks++;
      if (ar_log[2] !== 32'h0100_0400) begin errors++; $display("FAIL bp_third_addr: got %h, expected 01000400", ar_log[2]); end
    end
    checks++;
    if (words_popped !== 64) begin errors++; $display("FAIL bp_popped: got %0d, expected 64", words_popped); end
  endtask

  task automatic test_ar_delay();
    bit ok;
    do_reset(); release_reset(); clear_knobs();
    ar_delay = 5;
    pulse_start(1'b0);
    wait_ar(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ardly_timeout: got 0 handshakes, expected 1"); end
    checks++;
    if (ar_wait_last !== 5) begin errors++; $display("FAIL ardly_wait: got %0d, expected 5", ar_wait_last); end
    repeat (10) @(negedge clk_100Mhz);
    #2;
    checks++;
    if (ar_log.size() !== 1) begin errors++; $display("FAIL ardly_single: got %0d handshakes, expected 1", ar_log.size()); end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL ardly_state: got %0d, expected 2", state); end
  endtask

  task automatic test_errors();
    bit ok;
    do_reset(); release_reset(); clear_knobs();
    bad_rlast_beat = 10; bad_rresp_beat = 20;
    pulse_start(1'b0);
    wait_ar(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_advance: got %0d bursts, expected 2", ar_log.size()); end
    checks++;
    if (beats_total !== 64) begin errors++; $display("FAIL err_beats: got %0d, expected 64", beats_total); end
    checks++;
    if (rd_error !== 1'b1) begin errors++; $display("FAIL err_early_rlast: got %b, expected 1", rd_error); end

    do_reset(); release_reset(); clear_knobs();
    bad_rresp_beat = 20;
    pulse_start(1'b0);
    wait_ar(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rresp_advance: got %0d bursts, expected 2", ar_log.size()); end
    checks++;
    if (rd_error !== RRESP_ERR_EXP) begin errors++; $display("FAIL rresp_error: got %b, expected %b", rd_error, RRESP_ERR_EXP); end

    do_reset(); release_reset(); clear_knobs();
    drop_last = 1;
    pulse_start(1'b0);
    wait_ar(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nolast_advance: got %0d bursts, expected 2", ar_log.size()); end
    else begin
      checks++;
      if (ar_log[1] !== 32'h0100_0200) begin errors++; $display("FAIL nolast_addr: got %h, expected 01000200", ar_log[1]); end
    end
    checks++;
    if (rd_error !== 1'b1) begin errors++; $display("FAIL nolast_error: got %b, expected 1", rd_error); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found = 0;
    do_reset(); release_reset(); clear_knobs();
    pulse_start(1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_100Mhz); #2;
      if (ar_log.size() == 6 && phase == 1 && beat == 30) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach: got %0d bursts, expected beat 30 of burst 5", ar_log.size()); end
    rst = 1;
    #1;
    checks++;
    if ({state, ARVALID, RREADY, m_valid, m_sof, reader_done, rd_error} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b, expected 00000000", {state, ARVALID, RREADY, m_valid, m_sof, reader_done, rd_error});
    end
    checks++;
    if (ARADDR !== 32'h0) begin errors++; $display("FAIL midrst_araddr: got %h, expected 0", ARADDR); end
    checks++;
    if (fifo_level !== 8'd0) begin errors++; $display("FAIL midrst_level: got %0d, expected 0", fifo_level); end
    ar_log.delete(); words_popped = 0; sof_seen = 0; done_cnt = 0; beats_total = 0;
    release_reset();
    pulse_start(1'b0);
    wait_ar(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_restart: got 0 handshakes, expected 1"); end
    else begin
      checks++;
      if (ar_log[0] !== 32'h0100_0000) begin errors++; $display("FAIL midrst_addr: got %h, expected 01000000", ar_log[0]); end
    end
    repeat (100) @(negedge clk_100Mhz);
    #2;
    checks++;
    if (sof_seen !== 1) begin errors++; $display("FAIL midrst_sof: got %0d, expected 1", sof_seen); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_bfm();
    join_none
    test_reset();
    test_full_frame();
    test_buf1();
    test_backpressure();
    test_ar_delay();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_frame_reader.md
AXI4_FRAME_READER -- requirements
Module: axi4_frame_reader

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, 32, AXI address width.
REQ-002 Parameter AXI_DATA_WIDTH, 64, AXI read data width.
REQ-003 Parameter FRAME_BYTES, 153600, bytes per frame (320x240, 16 bpp).
REQ-004 Parameter BURST_BYTES, 512, bytes per burst (64 beats x 8 bytes).
REQ-005 Parameter FIFO_DEPTH, 128, output FIFO entries (two bursts).
REQ-006 Clock and reset: one clock, clk_100Mhz; reset rst is asynchronous and active-high.
REQ-007 Ports, in order, SHALL be:
 - clk_100Mhz  in  1  system clock.
 - rst  in  1  asynchronous active-high reset.
 - frame_start  in  1  start-of-frame request (writer_done).
 - buf_select  in  1  buffer last written.
 - ARADDR  out  32  burst address.
 - ARVALID  out  1  address valid.
 - ARREADY  in  1  address ready.
 - ARLEN  out  8  constant 63.
 - ARSIZE  out  3  constant 3'b011.
 - ARBURST  out  2  constant 2'b01 (INCR).
 - ARCACHE  out  4  constant 4'b1111.
 - ARPROT  out  3  constant 3'b010.
 - RDATA  in  64  read data.
 - RRESP  in  2  read response.
 - RLAST  in  1  last beat.
 - RVALID  in  1  data valid.
 - RREADY  out  1  data ready.
 - m_data  out  64  stream word (four pixels).
 - m_valid  out  1  stream valid.
 - m_ready  in  1  stream ready.
 - m_sof  out  1  high with the first word of a frame.
 - reader_done  out  1  one-cycle pulse at frame end.
 - rd_error  out  1  sticky protocol/response error.
 - state  out  2  FSM state (debug).
 - fifo_level  out  8  FIFO occupancy (0..128).

Function
REQ-008 States SHALL be IDLE=0, ADDR_SEND=1, DATA_RECV=2, NEXT=3.
REQ-009 IDLE: on frame_start=1, latch base = buf_select ? 32'h0110_0000 : 32'h0100_0000, set offset=0, set sof_pending=1, and go to ADDR_SEND.
REQ-010 ADDR_SEND: ARADDR=base+offset; assert ARVALID only when FIFO free entries >= 64; hold ARVALID and ARADDR stable until ARREADY; on ARVALID&ARREADY deassert ARVALID next cycle and go to DATA_RECV.
REQ-011 DATA_RECV: RREADY=1; each RVALID beat is pushed to the FIFO and increments beat_cnt (8-bit); on the beat with beat_cnt==63, go to NEXT and clear beat_cnt.
REQ-012 The first beat after sof_pending SHALL be stored with the sof tag set; sof_pending then clears.
REQ-013 NEXT: if offset==FRAME_BYTES-BURST_BYTES (153088), pulse reader_done for one cycle and go to IDLE; else offset+=512 and go to ADDR_SEND.
REQ-014 The FIFO is synchronous and first-word fall-through: m_valid = !empty; pop on m_valid&m_ready; m_data and m_sof come from the head entry (65-bit entries).
REQ-015 A simultaneous push and pop SHALL leave fifo_level unchanged; a push never occurs when full, which REQ-010 guarantees.
REQ-016 frame_start outside IDLE SHALL be ignored; a frame is 300 bursts.
REQ-017 RLAST at beat_cnt!=63, or missing at beat_cnt==63, SHALL set rd_error; the FSM still advances by count.
REQ-018 Offset is 32-bit with no wrap; base+offset does not carry beyond 0x0112_5800.

Reset
REQ-019 rst SHALL clear immediately: state=IDLE, ARVALID=0, RREADY=0, ARADDR=0, offset=0, beat_cnt=0, sof_pending=0, FIFO empty (m_valid=0, m_sof=0, fifo_level=0), reader_done=0, rd_error=0.
REQ-020 Reset mid-burst SHALL abandon the transaction and discard all buffered data.

Configuration
REQ-021 With macro AXI_RRESP_CHECK_EN defined, any accepted beat with RRESP!=2'b00 SHALL set rd_error sticky until reset.
REQ-022 Without AXI_RRESP_CHECK_EN, RRESP SHALL be ignored; rd_error reflects only REQ-017.

Verification
REQ-023 buf_select=0, frame_start pulse, ARREADY=1, RVALID=1, m_ready=1 -> first ARADDR=0x0100_0000, last ARADDR=0x0112_5600, 300 bursts, reader_done pulse once, m_sof only on word 0.
REQ-024 buf_select=1 -> first ARADDR=0x0110_0000.
REQ-025 m_ready=0 -> two bursts complete, fifo_level=128, ARVALID stays 0; one m_ready pop of 64 words -> next ARVALID.
REQ-026 ARREADY delayed 5 cycles -> ARADDR and ARVALID stable throughout, a single handshake.
REQ-027 RLAST on beat 10, plus one beat RRESP=2'b10 -> rd_error=1 (with AXI_RRESP_CHECK_EN), still 64 beats consumed.
REQ-028 rst asserted at beat 30 of burst 5 -> all outputs at reset values same cycle; next frame_start restarts at offset 0.
